esdi_serial_engine: RTL and testbench

//  Parametrised ESDI serial command/status engine. Takes one command word and a drive index from the
//  SoC, shifts the word plus odd parity to the drive over the TRANSFER REQ/ACK handshake, and can read
//  a status word back over CONFIG/STATUS DATA. It reports parity, timeout and attention results.
//  It sits between the soc_bd register block and the ESDI pads. All ESDI signals here are active-high

---
 rtl/esdi_pkg.sv | 24 ++
 rtl/esdi_sync.sv | 25 ++
 rtl/esdi_serial_engine.sv | 156 +++++++++++++++
 tb/tb_esdi_serial_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI serial command/status engine: state encoding,
// default payload widths and the odd-parity helper.
package esdi_pkg;

    localparam int ESDI_CMD_BITS    = 16;
    localparam int ESDI_STATUS_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        C_SETUP,
        C_REQ,
        C_REL,
        S_REQ,
        S_REL,
        RECOVER,
        DONE
    } esdi_state_t;

    // Zero-extension leaves the XOR reduction unchanged, so any payload up to 64 bits fits.
    function automatic logic odd_parity(input logic [63:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/esdi_sync.sv
// Multi-stage flip-flop synchroniser for one asynchronous ESDI input.
module esdi_sync
    import esdi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/esdi_serial_engine.sv
// ESDI serial engine: shifts a command word plus odd parity to the drive over the
// TRANSFER REQ/ACK handshake and optionally reads a status word back.
module esdi_serial_engine
    import esdi_pkg::*;
#(
    parameter int CMD_BITS       = ESDI_CMD_BITS,
    parameter int STATUS_BITS    = ESDI_STATUS_BITS,
    parameter int NUM_DRIVES     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               cmd_valid,
    output logic                                               cmd_ready,
    input  logic [CMD_BITS-1:0]                                cmd_word,
    input  logic [((NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1)-1:0] cmd_drive,
    input  logic                                               cmd_want_status,
    output logic                                               rsp_valid,
    output logic [STATUS_BITS-1:0]                             rsp_status,
    output logic                                               rsp_parity_err,
    output logic                                               rsp_timeout,
    output logic                                               rsp_attention,
    output logic                                               esdi_transfer_req,
    output logic                                               esdi_command_data,
    input  logic                                               esdi_transfer_ack,
    input  logic                                               esdi_confstat_data,
    input  logic                                               esdi_attention,
    output logic [NUM_DRIVES-1:0]                              esdi_drive_select
);

    localparam int DRV_W   = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
    localparam int BIT_MAX = (CMD_BITS > STATUS_BITS) ? CMD_BITS : STATUS_BITS;
    localparam int BW      = $clog2(BIT_MAX + 1);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    esdi_state_t            state_q, state_d;
    logic [CMD_BITS:0]      cmd_shift;
    logic [STATUS_BITS:0]   stat_shift;
    logic [BW-1:0]          bit_cnt;
    logic [CW-1:0]          cnt;
    logic                   want_status;
    logic                   timed_out;
    logic                   ack_s, conf_s, attn_s;
    logic                   accept, setup_done, wait_expired, cmd_last, stat_last;
    logic [NUM_DRIVES-1:0]  select_d;

    esdi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack  (.clk(clk), .rst(rst), .d(esdi_transfer_ack),  .q(ack_s));
    esdi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_conf (.clk(clk), .rst(rst), .d(esdi_confstat_data), .q(conf_s));
    esdi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_attn (.clk(clk), .rst(rst), .d(esdi_attention),     .q(attn_s));

    assign accept       = cmd_valid && (state_q == IDLE);
    assign setup_done   = (cnt == CW'(SETUP_CYCLES - 1));
    assign wait_expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign cmd_last     = (bit_cnt == BW'(CMD_BITS));
    assign stat_last    = (bit_cnt == BW'(STATUS_BITS));

    assign cmd_ready         = (state_q == IDLE);
    assign rsp_valid         = (state_q == DONE);
    assign esdi_transfer_req = (state_q == C_REQ) || (state_q == S_REQ);
    assign esdi_command_data = ((state_q == C_SETUP) || (state_q == C_REQ) || (state_q == C_REL))
                               && cmd_shift[CMD_BITS];

    // An out-of-range drive index leaves every select line low.
    always_comb begin
        select_d = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (cmd_drive == DRV_W'(i)) begin
                select_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = C_SETUP;
            C_SETUP: if (setup_done) state_d = C_REQ;
            C_REQ: begin
                if (ack_s)             state_d = C_REL;
                else if (wait_expired) state_d = RECOVER;
            end
            C_REL: begin
                if (!ack_s)            state_d = cmd_last ? (want_status ? S_REQ : DONE) : C_SETUP;
                else if (wait_expired) state_d = RECOVER;
            end
            S_REQ: begin
                if (ack_s)             state_d = S_REL;
                else if (wait_expired) state_d = RECOVER;
            end
            S_REL: begin
                if (!ack_s)            state_d = stat_last ? DONE : S_REQ;
                else if (wait_expired) state_d = RECOVER;
            end
            RECOVER: if (!ack_s || wait_expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cmd_shift         <= '0;
            stat_shift        <= '0;
            bit_cnt           <= '0;
            cnt               <= '0;
            want_status       <= 1'b0;
            timed_out         <= 1'b0;
            esdi_drive_select <= '0;
            rsp_status        <= '0;
            rsp_parity_err    <= 1'b0;
            rsp_timeout       <= 1'b0;
            rsp_attention     <= 1'b0;
        end else begin
            state_q <= state_d;

            // One counter serves both setup hold and ACK timeout; it restarts on every state change.
            if (state_d != state_q)      cnt <= '0;
            else if (cnt != CW'(CNT_MAX)) cnt <= cnt + 1'b1;

            if (accept) begin
                cmd_shift         <= {cmd_word, odd_parity(64'(cmd_word))};
                want_status       <= cmd_want_status;
                timed_out         <= 1'b0;
                bit_cnt           <= '0;
                stat_shift        <= '0;
                esdi_drive_select <= select_d;
                rsp_status        <= '0;
                rsp_parity_err    <= 1'b0;
                rsp_timeout       <= 1'b0;
                rsp_attention     <= 1'b0;
            end

            if (state_q == C_REL && state_d == C_SETUP) begin
                cmd_shift <= {cmd_shift[CMD_BITS-1:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (state_q == C_REL && state_d == S_REQ) bit_cnt <= '0;
            if (state_q == S_REL && state_d == S_REQ) bit_cnt <= bit_cnt + 1'b1;
            if (state_q == S_REQ && ack_s) stat_shift <= {stat_shift[STATUS_BITS-1:0], conf_s};
            if (state_d == RECOVER && state_q != RECOVER) timed_out <= 1'b1;

            // Results are captured on entry to DONE and hold until the next accept.
            if (state_d == DONE && state_q != DONE) begin
                rsp_attention  <= attn_s;
                rsp_timeout    <= timed_out;
                rsp_status     <= (want_status && !timed_out) ? stat_shift[STATUS_BITS:1] : '0;
                rsp_parity_err <= want_status && !timed_out && !(^stat_shift);
            end
        end
    end

endmodule

// File: tb/tb_esdi_serial_engine.sv
// Self-checking bench for esdi_serial_engine with a behavioural ESDI drive model.
module tb_esdi_serial_engine;

    localparam int CMD_BITS       = 16;
    localparam int STATUS_BITS    = 16;
    localparam int NUM_DRIVES     = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int SETUP_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 64;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [CMD_BITS-1:0]    cmd_word = '0;
    logic [1:0]             cmd_drive = '0;
    logic                   cmd_want_status = 1'b0;
    logic                   rsp_valid;
    logic [STATUS_BITS-1:0] rsp_status;
    logic                   rsp_parity_err, rsp_timeout, rsp_attention;
    logic                   esdi_transfer_req, esdi_command_data;
    logic                   esdi_transfer_ack = 1'b0;
    logic                   esdi_confstat_data = 1'b0;
    logic                   esdi_attention = 1'b0;
    logic [NUM_DRIVES-1:0]  esdi_drive_select;

    int checks = 0;
    int fails  = 0;

    esdi_serial_engine #(
        .CMD_BITS(CMD_BITS), .STATUS_BITS(STATUS_BITS), .NUM_DRIVES(NUM_DRIVES),
        .SYNC_STAGES(SYNC_STAGES), .SETUP_CYCLES(SETUP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
        .cmd_drive(cmd_drive), .cmd_want_status(cmd_want_status),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_parity_err(rsp_parity_err),
        .rsp_timeout(rsp_timeout), .rsp_attention(rsp_attention),
        .esdi_transfer_req(esdi_transfer_req), .esdi_command_data(esdi_command_data),
        .esdi_transfer_ack(esdi_transfer_ack), .esdi_confstat_data(esdi_confstat_data),
        .esdi_attention(esdi_attention), .esdi_drive_select(esdi_drive_select)
    );

    always #5 clk = ~clk;

    // Drive model: ACK follows REQ three clocks later, status bits are presented on each status REQ.
    bit                   ack_enable = 1'b1;
    logic [STATUS_BITS:0] stat_to_send = '0;
    logic [CMD_BITS:0]    wire_bits = '0;
    logic [2:0]           req_hist = '0;
    logic                 prev_req = 1'b0, prev_data = 1'b0;
    int                   req_rises = 0, stable = 0, req_run = 0, last_req_run = 0;
    int                   setup_viol = 0, hold_viol = 0, rsp_pulses = 0;

    always @(negedge clk) begin
        if (rst) begin
            req_hist = '0; req_rises = 0; prev_req = 1'b0; prev_data = 1'b0;
            stable = 0; req_run = 0;
            esdi_transfer_ack = 1'b0; esdi_confstat_data = 1'b0;
        end else begin
            if (esdi_command_data !== prev_data) stable = 0;
            else if (stable < 1000) stable++;
            if (esdi_transfer_req && !prev_req) begin
                req_rises++;
                if (req_rises <= CMD_BITS + 1) begin
                    if (stable < SETUP_CYCLES) setup_viol++;
                    wire_bits = {wire_bits[CMD_BITS-1:0], esdi_command_data};
                end else if (req_rises <= CMD_BITS + STATUS_BITS + 2) begin
                    esdi_confstat_data = stat_to_send[CMD_BITS + STATUS_BITS + 2 - req_rises];
                end
            end else if (esdi_transfer_req && esdi_command_data !== prev_data
                         && req_rises <= CMD_BITS + 1) begin
                hold_viol++;
            end
            if (esdi_transfer_req) req_run++;
            else if (prev_req) begin
                last_req_run = req_run;
                req_run = 0;
            end
            if (rsp_valid) begin
                rsp_pulses++;
                req_rises = 0;
            end
            prev_req  = esdi_transfer_req;
            prev_data = esdi_command_data;
            req_hist  = {req_hist[1:0], esdi_transfer_req};
            esdi_transfer_ack = ack_enable && req_hist[2];
        end
    end

    // Captured response of the most recent command
    bit                     r_ok, r_acc;
    int                     r_ready_busy;
    logic [STATUS_BITS-1:0] r_status;
    logic                   r_perr, r_tmo, r_attn;
    logic [NUM_DRIVES-1:0]  r_sel;

    task automatic run_cmd(input logic [CMD_BITS-1:0] w, input logic [1:0] d,
                           input logic ws, input bit hold_valid);
        @(negedge clk);
        r_acc = cmd_ready;
        cmd_valid = 1'b1; cmd_word = w; cmd_drive = d; cmd_want_status = ws;
        @(negedge clk);
        if (hold_valid) begin
            cmd_word = ~w; cmd_drive = d + 2'd1;
        end else begin
            cmd_valid = 1'b0;
        end
        r_ok = 1'b0; r_ready_busy = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rsp_valid) begin
                r_ok = 1'b1; r_status = rsp_status; r_perr = rsp_parity_err;
                r_tmo = rsp_timeout; r_attn = rsp_attention; r_sel = esdi_drive_select;
                break;
            end
            if (cmd_ready) r_ready_busy++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (esdi_transfer_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b want 0", esdi_transfer_req); end
        checks++; if (esdi_command_data !== 1'b0) begin fails++; $display("[TB] FAIL reset_data got %b want 0", esdi_command_data); end
        checks++; if (esdi_drive_select !== '0) begin fails++; $display("[TB] FAIL reset_select got %b want 0000", esdi_drive_select); end
        checks++; if ({rsp_status, rsp_parity_err, rsp_timeout, rsp_attention} !== '0) begin
            fails++; $display("[TB] FAIL reset_rsp_fields got %h want 0", {rsp_status, rsp_parity_err, rsp_timeout, rsp_attention});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_command_no_status;
        int p0;
        logic [CMD_BITS:0] exp_wire;
        exp_wire = {16'hA5C3, 1'b1};
        p0 = rsp_pulses; ack_enable = 1'b1;
        run_cmd(16'hA5C3, 2'd1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (r_ok !== 1'b1 || r_acc !== 1'b1) begin fails++; $display("[TB] FAIL a5c3_done got ok=%b acc=%b want 1,1", r_ok, r_acc); end
        checks++; if (wire_bits !== exp_wire) begin fails++; $display("[TB] FAIL a5c3_wire got %b want %b", wire_bits, exp_wire); end
        checks++; if (setup_viol !== 0 || hold_viol !== 0) begin fails++; $display("[TB] FAIL a5c3_setup got setup=%0d hold=%0d want 0,0", setup_viol, hold_viol); end
        checks++; if (rsp_pulses - p0 !== 1) begin fails++; $display("[TB] FAIL a5c3_pulses got %0d want 1", rsp_pulses - p0); end
        checks++; if (r_tmo !== 1'b0 || r_status !== '0) begin fails++; $display("[TB] FAIL a5c3_rsp got tmo=%b status=%h want 0,0", r_tmo, r_status); end
    endtask

    task automatic test_status_parity;
        for (int par = 0; par < 2; par++) begin
            stat_to_send = {16'h1234, par[0]};
            run_cmd(16'h0000, 2'd0, 1'b1, 1'b0);
            checks++; if (r_ok !== 1'b1 || r_status !== 16'h1234) begin
                fails++; $display("[TB] FAIL status_word par=%0d got ok=%b status=%h want 1,1234", par, r_ok, r_status);
            end
            checks++; if (r_perr !== par[0]) begin
                fails++; $display("[TB] FAIL status_parity par=%0d got %b want %b", par, r_perr, par[0]);
            end
        end
    endtask

    task automatic test_timeout;
        ack_enable = 1'b0;
        run_cmd(16'h5A5A, 2'd3, 1'b1, 1'b0);
        checks++; if (r_ok !== 1'b1 || r_tmo !== 1'b1) begin fails++; $display("[TB] FAIL timeout_flag got ok=%b tmo=%b want 1,1", r_ok, r_tmo); end
        checks++; if (r_status !== '0 || r_perr !== 1'b0) begin fails++; $display("[TB] FAIL timeout_status got %h/%b want 0/0", r_status, r_perr); end
        checks++; if (last_req_run !== TIMEOUT_CYCLES) begin fails++; $display("[TB] FAIL timeout_req_len got %0d want %0d", last_req_run, TIMEOUT_CYCLES); end
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL timeout_ready got %b want 1", cmd_ready); end
        ack_enable = 1'b1;
        repeat (6) @(negedge clk);
        run_cmd(16'h0F0F, 2'd3, 1'b0, 1'b0);
        checks++; if (r_ok !== 1'b1 || r_tmo !== 1'b0 || wire_bits !== {16'h0F0F, 1'b1}) begin
            fails++; $display("[TB] FAIL timeout_recover got ok=%b tmo=%b wire=%b", r_ok, r_tmo, wire_bits);
        end
    endtask

    task automatic test_drive_select;
        run_cmd(16'h1111, 2'd2, 1'b0, 1'b0);
        checks++; if (r_sel !== 4'b0100) begin fails++; $display("[TB] FAIL select_2 got %b want 0100", r_sel); end
        repeat (3) @(negedge clk);
        checks++; if (esdi_drive_select !== 4'b0100) begin fails++; $display("[TB] FAIL select_2_held got %b want 0100", esdi_drive_select); end
        run_cmd(16'h2222, 2'd0, 1'b0, 1'b0);
        checks++; if (r_sel !== 4'b0001) begin fails++; $display("[TB] FAIL select_0 got %b want 0001", r_sel); end
    endtask

    task automatic test_reset_mid_status;
        bit hit;
        int p0;
        stat_to_send = {STATUS_BITS+1{1'b1}};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_word = 16'hBEEF; cmd_drive = 2'd1; cmd_want_status = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (req_rises >= CMD_BITS + 1 + 8) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (hit !== 1'b1) begin fails++; $display("[TB] FAIL midreset_reach got %b want 1", hit); end
        p0 = rsp_pulses;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (esdi_transfer_req !== 1'b0 || esdi_drive_select !== '0) begin
            fails++; $display("[TB] FAIL midreset_outputs got req=%b sel=%b want 0,0000", esdi_transfer_req, esdi_drive_select);
        end
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_ready got ready=%b valid=%b want 1,0", cmd_ready, rsp_valid);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rsp_pulses !== p0) begin fails++; $display("[TB] FAIL midreset_no_rsp got %0d want %0d", rsp_pulses, p0); end
        stat_to_send = {16'hC0DE, 1'b0};
        run_cmd(16'h8001, 2'd2, 1'b1, 1'b0);
        checks++; if (r_ok !== 1'b1 || r_status !== 16'hC0DE || wire_bits !== {16'h8001, 1'b1}) begin
            fails++; $display("[TB] FAIL midreset_fresh got ok=%b status=%h wire=%b", r_ok, r_status, wire_bits);
        end
    endtask

    task automatic test_attention_busy;
        int p0;
        esdi_attention = 1'b1;
        repeat (4) @(negedge clk);
        p0 = rsp_pulses;
        run_cmd(16'h3C96, 2'd1, 1'b0, 1'b1);
        checks++; if (r_attn !== 1'b1) begin fails++; $display("[TB] FAIL attention got %b want 1", r_attn); end
        checks++; if (r_ready_busy !== 0) begin fails++; $display("[TB] FAIL busy_ready got %0d cycles want 0", r_ready_busy); end
        checks++; if (wire_bits !== {16'h3C96, 1'b1} || r_sel !== 4'b0010) begin
            fails++; $display("[TB] FAIL busy_ignored got wire=%b sel=%b want %b 0010", wire_bits, r_sel, {16'h3C96, 1'b1});
        end
        repeat (4) @(negedge clk);
        checks++; if (rsp_pulses - p0 !== 1) begin fails++; $display("[TB] FAIL busy_pulses got %0d want 1", rsp_pulses - p0); end
        esdi_attention = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random;
        logic [CMD_BITS-1:0]    w;
        logic [STATUS_BITS-1:0] s;
        logic                   p, ws;
        logic [1:0]             d;
        logic [CMD_BITS:0]      exp_wire;
        for (int n = 0; n < 6; n++) begin
            w = CMD_BITS'($urandom); s = STATUS_BITS'($urandom);
            p = 1'($urandom); ws = 1'($urandom); d = 2'($urandom_range(0, 3));
            stat_to_send = {s, p};
            exp_wire = {w, 1'b0};
            exp_wire[0] = (($countones(w) % 2) == 0);
            run_cmd(w, d, ws, 1'b0);
            checks++; if (r_ok !== 1'b1 || wire_bits !== exp_wire) begin
                fails++; $display("[TB] FAIL rand_wire n=%0d got ok=%b wire=%b want %b", n, r_ok, wire_bits, exp_wire);
            end
            checks++; if (r_status !== (ws ? s : '0)) begin
                fails++; $display("[TB] FAIL rand_status n=%0d got %h want %h", n, r_status, ws ? s : 16'h0);
            end
            checks++; if (r_perr !== (ws && ((($countones(s) + p) % 2) == 0))) begin
                fails++; $display("[TB] FAIL rand_parity n=%0d got %b", n, r_perr);
            end
            checks++; if (r_sel !== (4'b0001 << d) || r_tmo !== 1'b0 || r_attn !== 1'b0) begin
                fails++; $display("[TB] FAIL rand_misc n=%0d got sel=%b tmo=%b attn=%b want sel=%b", n, r_sel, r_tmo, r_attn, 4'b0001 << d);
            end
        end
        checks++; if (setup_viol !== 0 || hold_viol !== 0) begin
            fails++; $display("[TB] FAIL setup_hold_total got setup=%0d hold=%0d want 0,0", setup_viol, hold_viol);
        end
    endtask

    initial begin
        test_reset();
        test_command_no_status();
        test_status_parity();
        test_timeout();
        test_drive_select();
        test_reset_mid_status();
        test_attention_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
